updown_sweep_ctrl: RTL and testbench

Sweep controller for a WIDTH-bit synchronous up/down counter. It owns the counter register and sequences it through a programmed number of triangular sweeps, lo→hi→lo. It exposes the count `Q` and the direction `sel` using the counter convention (`sel`=1 is down). Test-pattern and stimulus logic uses it as a start/done peripheral.

---
 rtl/updown_sweep_ctrl_if.sv | 26 ++
 rtl/updown_sweep_ctrl.sv | 178 +++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_sweep_ctrl_if.sv
// Start/done handshake and counter outputs of the sweep controller.
// The master drives run requests and bounds; the slave is the controller itself.
interface updown_sweep_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [3:0]       sweeps;
  logic [WIDTH-1:0] Q;
  logic             sel;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, lo, hi, sweeps,
    input  Q, sel, busy, done, err
  );

  modport slave (
    input  start, abort, lo, hi, sweeps,
    output Q, sel, busy, done, err
  );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Triangular lo->hi->lo sweep sequencer owning a WIDTH-bit up/down counter.
// Define SWEEP_DWELL_EN to hold DWELL extra cycles at hi and at intermediate lo turnarounds.
module updown_sweep_ctrl #(
  parameter int WIDTH = 3,
  parameter int DWELL = 2
) (
  input logic                clk,
  input logic                clear,
  updown_sweep_ctrl_if.slave bus
);

`ifdef SWEEP_DWELL_EN
  typedef enum logic [2:0] {IDLE, UP, DOWN, DONE, HOLD_HI, HOLD_LO} state_t;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  logic [DW-1:0] dwell_q, dwell_d;
`else
  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;
  logic unused_dwell;
  assign unused_dwell = (DWELL != 0);
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       rem_q, rem_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
`ifdef SWEEP_DWELL_EN
    dwell_d = dwell_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if ((bus.lo >= bus.hi) || (bus.sweeps == 4'd0)) begin
            err_d = 1'b1;
          end else begin
            lo_d    = bus.lo;
            hi_d    = bus.hi;
            rem_d   = bus.sweeps;
            q_d     = bus.lo;
            sel_d   = 1'b0;
            state_d = UP;
          end
        end
      end
      UP: begin
        if (q_q != hi_q) begin
          q_d = q_q + 1'b1;
        end else begin
`ifdef SWEEP_DWELL_EN
          if (DWELL == 0) begin
            q_d     = hi_q - 1'b1;
            sel_d   = 1'b1;
            state_d = DOWN;
          end else begin
            dwell_d = '0;
            state_d = HOLD_HI;
          end
`else
          q_d     = hi_q - 1'b1;
          sel_d   = 1'b1;
          state_d = DOWN;
`endif
        end
      end
      DOWN: begin
        if (q_q != lo_q) begin
          q_d = q_q - 1'b1;
        end else if (rem_q == 4'd1) begin
          state_d = DONE;
        end else begin
          rem_d = rem_q - 1'b1;
`ifdef SWEEP_DWELL_EN
          if (DWELL == 0) begin
            q_d     = lo_q + 1'b1;
            sel_d   = 1'b0;
            state_d = UP;
          end else begin
            dwell_d = '0;
            state_d = HOLD_LO;
          end
`else
          q_d     = lo_q + 1'b1;
          sel_d   = 1'b0;
          state_d = UP;
`endif
        end
      end
`ifdef SWEEP_DWELL_EN
      // Direction only flips when the hold is over, so sel stays on the old segment while held.
      HOLD_HI: begin
        if (dwell_q == DW'(DWELL - 1)) begin
          q_d     = hi_q - 1'b1;
          sel_d   = 1'b1;
          state_d = DOWN;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      HOLD_LO: begin
        if (dwell_q == DW'(DWELL - 1)) begin
          q_d     = lo_q + 1'b1;
          sel_d   = 1'b0;
          state_d = UP;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
`endif
      DONE: begin
        sel_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort lets the counter take the step of this edge, then parks in IDLE without done.
    if (bus.abort && busy_q) begin
      sel_d   = 1'b0;
      state_d = IDLE;
    end

    busy_d = (state_d == UP) || (state_d == DOWN);
`ifdef SWEEP_DWELL_EN
    busy_d = busy_d || (state_d == HOLD_HI) || (state_d == HOLD_LO);
`endif
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      q_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      rem_q   <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SWEEP_DWELL_EN
      dwell_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SWEEP_DWELL_EN
      dwell_q <= dwell_d;
`endif
    end
  end

  assign bus.Q    = q_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: a run-sequence model expands each accepted start into the
// full list of per-cycle outputs, checked every cycle, plus directed literal runs.
module tb_updown_sweep_ctrl;
  localparam int WIDTH = 3;
  localparam int DWELL = 2;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  updown_sweep_ctrl_if #(.WIDTH(WIDTH)) bus ();

  updown_sweep_ctrl #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             sel;
    logic             busy;
    logic             done;
  } ent_t;

  ent_t             exp_q[$];
  ent_t             ent;
  logic [WIDTH-1:0] m_q;
  logic             m_sel, m_busy, m_done, m_err;
  bit               model_valid = 1'b0;

  function automatic void pushEnt(int v, logic s, logic b, logic d);
    ent_t x;
    x.q    = WIDTH'(v);
    x.sel  = s;
    x.busy = b;
    x.done = d;
    exp_q.push_back(x);
  endfunction

  // One entry per cycle of the run: N triangles, optional holds, and a final DONE cycle.
  function automatic void buildRun(int l, int h, int n);
    int hold;
`ifdef SWEEP_DWELL_EN
    hold = DWELL;
`else
    hold = 0;
`endif
    exp_q.delete();
    for (int s = 1; s <= n; s++) begin
      for (int v = (s == 1) ? l : l + 1; v <= h; v++) pushEnt(v, 1'b0, 1'b1, 1'b0);
      for (int d = 0; d < hold; d++) pushEnt(h, 1'b0, 1'b1, 1'b0);
      for (int v = h - 1; v >= l; v--) pushEnt(v, 1'b1, 1'b1, 1'b0);
      if (s < n) for (int d = 0; d < hold; d++) pushEnt(l, 1'b1, 1'b1, 1'b0);
    end
    pushEnt(l, 1'b1, 1'b0, 1'b1);
  endfunction

  always @(posedge clk) begin
    m_err = 1'b0;
    if (clear) begin
      exp_q.delete();
      m_q = '0; m_sel = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      model_valid = 1'b1;
    end else if (m_busy && exp_q.size() != 0) begin
      ent = exp_q.pop_front();
      m_q = ent.q;
      if (bus.abort) begin
        m_sel = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        exp_q.delete();
      end else begin
        m_sel = ent.sel; m_busy = ent.busy; m_done = ent.done;
      end
    end else if (m_done) begin
      m_done = 1'b0;
      m_sel  = 1'b0;
    end else if (bus.start) begin
      if (int'(bus.lo) >= int'(bus.hi) || bus.sweeps == 4'd0) begin
        m_err = 1'b1;
      end else begin
        buildRun(int'(bus.lo), int'(bus.hi), int'(bus.sweeps));
        ent = exp_q.pop_front();
        m_q = ent.q; m_sel = ent.sel; m_busy = ent.busy; m_done = ent.done;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("cmp_q",    32'(bus.Q),    32'(m_q));
      checkOutput("cmp_sel",  32'(bus.sel),  32'(m_sel));
      checkOutput("cmp_busy", 32'(bus.busy), 32'(m_busy));
      checkOutput("cmp_done", 32'(bus.done), 32'(m_done));
      checkOutput("cmp_err",  32'(bus.err),  32'(m_err));
    end
  end

  task automatic applyStimulus(input logic clr, input logic st, input logic ab,
                               input int l, input int h, input int n);
    clear       = clr;
    bus.start   = st;
    bus.abort   = ab;
    bus.lo      = WIDTH'(l);
    bus.hi      = WIDTH'(h);
    bus.sweeps  = 4'(n);
    @(posedge clk);
    #2;
  endtask

  task automatic sampleLate();
    @(negedge clk);
    #1;
  endtask

  task automatic literalRun(input string tag, input int l, input int h, input int n,
                            input int qs[$], input int ss[$]);
    applyStimulus(1'b0, 1'b1, 1'b0, l, h, n);
    for (int i = 0; i <= qs.size(); i++) begin
      sampleLate();
      if (i < qs.size()) begin
        checkOutput({tag, "_q"},       32'(bus.Q),    32'(qs[i]));
        checkOutput({tag, "_sel"},     32'(bus.sel),  32'(ss[i]));
        checkOutput({tag, "_busy"},    32'(bus.busy), 32'd1);
        checkOutput({tag, "_model_q"}, 32'(m_q),      32'(qs[i]));
      end else begin
        checkOutput({tag, "_done"},     32'(bus.done), 32'd1);
        checkOutput({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_model_done"}, 32'(m_done), 32'd1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, l, h, n);
    end
    sampleLate();
    checkOutput({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_idle_sel"},  32'(bus.sel),  32'd0);
  endtask

  int q1[$], s1[$], q2[$], s2[$];
  int busy_cnt, done_cnt, st_r, ab_r, clr_r, l_r, h_r, n_r;

  initial begin
    clear = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.lo = '0; bus.hi = '0; bus.sweeps = '0;

    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    sampleLate();
    checkOutput("rst_q",    32'(bus.Q),    32'd0);
    checkOutput("rst_sel",  32'(bus.sel),  32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_err",  32'(bus.err),  32'd0);

`ifdef SWEEP_DWELL_EN
    q1 = '{0, 1, 2, 2, 2, 1, 0};
    s1 = '{0, 0, 0, 0, 0, 1, 1};
    literalRun("tri1", 0, 2, 1, q1, s1);
    q2 = '{0, 1, 2, 2, 2, 1, 0, 0, 0, 1, 2, 2, 2, 1, 0};
    s2 = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    literalRun("tri2", 0, 2, 2, q2, s2);
`else
    q1 = '{0, 1, 2, 1, 0};
    s1 = '{0, 0, 0, 1, 1};
    literalRun("tri1", 0, 2, 1, q1, s1);
    q2 = '{1, 2, 3, 4, 3, 2, 1, 2, 3, 4, 3, 2, 1};
    s2 = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    literalRun("tri2", 1, 4, 2, q2, s2);
`endif

    // Rejected starts: equal bounds, then zero sweeps.
    applyStimulus(1'b0, 1'b1, 1'b0, 5, 5, 1);
    sampleLate();
    checkOutput("rej_eq_err",  32'(bus.err),  32'd1);
    checkOutput("rej_eq_busy", 32'(bus.busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5, 5, 1);
    sampleLate();
    checkOutput("rej_eq_err_off", 32'(bus.err), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, 3, 0);
    sampleLate();
    checkOutput("rej_n0_err",  32'(bus.err),  32'd1);
    checkOutput("rej_n0_busy", 32'(bus.busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1, 3, 0);

    // Abort on the edge leaving Q=5.
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 7, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 7, 1);
    sampleLate();
    checkOutput("abort_pre_q", 32'(bus.Q), 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 7, 1);
    sampleLate();
    checkOutput("abort_q",    32'(bus.Q),    32'd6);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 7, 1);
      sampleLate();
      done_cnt += int'(bus.done);
    end
    checkOutput("abort_q_frozen", 32'(bus.Q), 32'd6);
    checkOutput("abort_no_done",  32'(done_cnt), 32'd0);

    // Clear in the middle of a run.
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 7, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 7, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 7, 1);
    sampleLate();
    checkOutput("midclr_q",    32'(bus.Q),    32'd0);
    checkOutput("midclr_busy", 32'(bus.busy), 32'd0);

    // Start while busy must not disturb the run.
    applyStimulus(1'b0, 1'b1, 1'b0, 2, 5, 1);
    busy_cnt = 0; done_cnt = 0;
    sampleLate();
    busy_cnt += int'(bus.busy);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, (i == 2), 1'b0, (i == 2) ? 0 : 2, 7, 3);
      sampleLate();
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
    end
`ifdef SWEEP_DWELL_EN
    checkOutput("busy_start_cnt", 32'(busy_cnt), 32'(7 + DWELL));
`else
    checkOutput("busy_start_cnt", 32'(busy_cnt), 32'd7);
`endif
    checkOutput("busy_start_done", 32'(done_cnt), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      clr_r = ($urandom_range(0, 199) == 0) ? 1 : 0;
      st_r  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ab_r  = ($urandom_range(0, 59) == 0) ? 1 : 0;
      l_r   = $urandom_range(0, MAXV);
      h_r   = $urandom_range(0, MAXV);
      n_r   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
      applyStimulus(clr_r[0], st_r[0], ab_r[0], l_r, h_r, n_r);
    end
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    sampleLate();
    checkOutput("drain_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
